// File: rtl/ex_stage_mc.sv
// Multi-cycle execute stage: 1-cycle ALU, MUL_CYCLES multiply, XLEN-cycle restoring divide (EX_DIV_EN).
// ready_o is low while a multi-cycle op runs; decode holds valid_i; writeback never stalls.
module ex_stage_mc #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [3:0]            operator_i,
  input  logic [XLEN-1:0]       operand_a_i,
  input  logic [XLEN-1:0]       operand_b_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  rd_wr_en_i,
  output logic                  valid_o,
  output logic                  reg_we_o,
  output logic [REG_ADDR_W-1:0] wr_addr_o,
  output logic [XLEN-1:0]       rd_wdata_o,
  output logic                  illegal_o
);

  localparam int SHW     = $clog2(XLEN);
  localparam int CNT_MAX = (XLEN > MUL_CYCLES) ? XLEN : MUL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam bit MUL_MC  = (MUL_CYCLES > 1);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REMU  = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef EX_DIV_EN
    S_DIV  = 2'd2,
`endif
    S_MUL  = 2'd1
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [3:0]            op_q, op_d;
  logic [XLEN-1:0]       a_q, a_d, b_q, b_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  we_q, we_d;
  logic                  valid_q, valid_d;
  logic                  reg_we_q, reg_we_d;
  logic                  illegal_q, illegal_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;

  logic                  accept, is_mul, mul_multi, div_multi, last_cnt;
  logic [XLEN-1:0]       mul_a, mul_b, alu_res;
  logic [2*XLEN-1:0]     prod;
  logic                  alu_illegal;

  assign accept    = valid_i & (state_q == S_IDLE);
  assign is_mul    = (operator_i == OP_MUL) | (operator_i == OP_MULHU);
  assign mul_multi = is_mul & MUL_MC;
  assign last_cnt  = (cnt_q == CNT_W'(1));

  // One multiplier: fed from the inputs for single-cycle use, from latched operands in S_MUL.
  assign mul_a = (state_q == S_MUL) ? a_q : operand_a_i;
  assign mul_b = (state_q == S_MUL) ? b_q : operand_b_i;
  assign prod  = {{XLEN{1'b0}}, mul_a} * {{XLEN{1'b0}}, mul_b};

`ifdef EX_DIV_EN
  logic [XLEN-1:0] rem_q, rem_d, quo_nxt, rem_nxt;
  logic [XLEN:0]   div_shift, div_diff;
  logic            div_ge;

  assign div_multi = ((operator_i == OP_DIVU) | (operator_i == OP_REMU)) & (operand_b_i != '0);
  assign div_shift = {rem_q, a_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_ge    = ~div_diff[XLEN];
  assign rem_nxt   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
  assign quo_nxt   = {a_q[XLEN-2:0], div_ge};
`else
  assign div_multi = 1'b0;
`endif

  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    case (operator_i)
      OP_ADD:   alu_res = operand_a_i + operand_b_i;
      OP_SUB:   alu_res = operand_a_i - operand_b_i;
      OP_AND:   alu_res = operand_a_i & operand_b_i;
      OP_OR:    alu_res = operand_a_i | operand_b_i;
      OP_XOR:   alu_res = operand_a_i ^ operand_b_i;
      OP_SLL:   alu_res = operand_a_i << operand_b_i[SHW-1:0];
      OP_SRL:   alu_res = operand_a_i >> operand_b_i[SHW-1:0];
      OP_SRA:   alu_res = $unsigned($signed(operand_a_i) >>> operand_b_i[SHW-1:0]);
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(operand_a_i) < $signed(operand_b_i)};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, operand_a_i < operand_b_i};
      OP_MUL:   alu_res = prod[XLEN-1:0];
      OP_MULHU: alu_res = prod[2*XLEN-1:XLEN];
`ifdef EX_DIV_EN
      OP_DIVU:  alu_res = '1;
      OP_REMU:  alu_res = operand_a_i;
`endif
      default:  alu_illegal = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept && mul_multi) begin
          state_d = S_MUL;
          cnt_d   = CNT_W'(MUL_CYCLES - 1);
        end
`ifdef EX_DIV_EN
        else if (accept && div_multi) begin
          state_d = S_DIV;
          cnt_d   = CNT_W'(XLEN);
        end
`endif
      end
      S_MUL: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (last_cnt) state_d = S_IDLE;
      end
`ifdef EX_DIV_EN
      S_DIV: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (last_cnt) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    valid_d   = 1'b0;
    reg_we_d  = 1'b0;
    illegal_d = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept && !mul_multi && !div_multi) begin
          valid_d   = 1'b1;
          illegal_d = alu_illegal;
          waddr_d   = rd_addr_i;
          wdata_d   = alu_illegal ? '0 : alu_res;
          reg_we_d  = rd_wr_en_i & (rd_addr_i != '0) & ~alu_illegal;
        end
      end
      S_MUL: begin
        if (last_cnt) begin
          valid_d  = 1'b1;
          waddr_d  = rd_q;
          wdata_d  = (op_q == OP_MULHU) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
          reg_we_d = we_q & (rd_q != '0);
        end
      end
`ifdef EX_DIV_EN
      S_DIV: begin
        if (last_cnt) begin
          valid_d  = 1'b1;
          waddr_d  = rd_q;
          wdata_d  = (op_q == OP_DIVU) ? quo_nxt : rem_nxt;
          reg_we_d = we_q & (rd_q != '0);
        end
      end
`endif
      default: ;
    endcase
  end

  // Operand latch; a_q doubles as the quotient shift register during a divide.
  always_comb begin
    op_d = op_q;
    a_d  = a_q;
    b_d  = b_q;
    rd_d = rd_q;
    we_d = we_q;
`ifdef EX_DIV_EN
    rem_d = rem_q;
`endif
    if (accept) begin
      op_d = operator_i;
      a_d  = operand_a_i;
      b_d  = operand_b_i;
      rd_d = rd_addr_i;
      we_d = rd_wr_en_i;
`ifdef EX_DIV_EN
      rem_d = '0;
    end else if (state_q == S_DIV) begin
      a_d   = quo_nxt;
      rem_d = rem_nxt;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      valid_q   <= 1'b0;
      reg_we_q  <= 1'b0;
      illegal_q <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
`ifdef EX_DIV_EN
      rem_q     <= '0;
`endif
    end else begin
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rd_q      <= rd_d;
      we_q      <= we_d;
      valid_q   <= valid_d;
      reg_we_q  <= reg_we_d;
      illegal_q <= illegal_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
`ifdef EX_DIV_EN
      rem_q     <= rem_d;
`endif
    end
  end

  assign ready_o    = (state_q == S_IDLE);
  assign valid_o    = valid_q;
  assign reg_we_o   = reg_we_q;
  assign illegal_o  = illegal_q;
  assign wr_addr_o  = waddr_q;
  assign rd_wdata_o = wdata_q;

endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed bench for ex_stage_mc (XLEN=32, MUL_CYCLES=2); divide tests run when EX_DIV_EN is defined.
module tb_ex_stage_mc;

  localparam int XLEN = 32;
  localparam int RAW  = 5;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            valid_i;
  logic            ready_o;
  logic [3:0]      operator_i;
  logic [XLEN-1:0] operand_a_i, operand_b_i;
  logic [RAW-1:0]  rd_addr_i;
  logic            rd_wr_en_i;
  logic            valid_o, reg_we_o, illegal_o;
  logic [RAW-1:0]  wr_addr_o;
  logic [XLEN-1:0] rd_wdata_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  ex_stage_mc #(.XLEN(XLEN), .MUL_CYCLES(2), .REG_ADDR_W(RAW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .operator_i(operator_i), .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
    .rd_addr_i(rd_addr_i), .rd_wr_en_i(rd_wr_en_i), .valid_o(valid_o),
    .reg_we_o(reg_we_o), .wr_addr_o(wr_addr_o), .rd_wdata_o(rd_wdata_o),
    .illegal_o(illegal_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic we);
    valid_i     = 1'b1;
    operator_i  = op;
    operand_a_i = a;
    operand_b_i = b;
    rd_addr_i   = rd;
    rd_wr_en_i  = we;
  endtask

  task automatic idle();
    valid_i = 1'b0;
  endtask

  // Issue a multi-cycle op, count cycles with ready_o low, then check the result pulse.
  task automatic run_multi(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int exp_low, input logic [31:0] exp_dat);
    int  low;
    logic early;
    low   = 0;
    early = 1'b0;
    drive(op, a, b, 5'd4, 1'b1);
    tick();
    idle();
    for (int i = 0; i < 40; i++) begin
      if (ready_o) break;
      if (valid_o) early = 1'b1;
      low++;
      tick();
    end
    chk({tag, "_ready_low"}, 64'(low), 64'(exp_low));
    chk({tag, "_early_vld"}, 64'(early), 64'd0);
    chk({tag, "_vld"}, 64'(valid_o), 64'd1);
    chk({tag, "_dat"}, 64'(rd_wdata_o), 64'(exp_dat));
    chk({tag, "_we"}, 64'(reg_we_o), 64'd1);
  endtask

  initial begin
    rst_ni = 1'b0;
    valid_i = 1'b0; operator_i = '0; operand_a_i = '0; operand_b_i = '0;
    rd_addr_i = '0; rd_wr_en_i = 1'b0;
    tick(); tick();
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_vld", 64'(valid_o), 64'd0);
    chk("rst_we", 64'(reg_we_o), 64'd0);
    chk("rst_ill", 64'(illegal_o), 64'd0);
    chk("rst_addr", 64'(wr_addr_o), 64'd0);
    chk("rst_dat", 64'(rd_wdata_o), 64'd0);
    rst_ni = 1'b1;
    tick();

    drive(4'd0, 32'h5, 32'h3, 5'd7, 1'b1);
    tick();
    chk("add_vld", 64'(valid_o), 64'd1);
    chk("add_we", 64'(reg_we_o), 64'd1);
    chk("add_addr", 64'(wr_addr_o), 64'd7);
    chk("add_dat", 64'(rd_wdata_o), 64'h8);
    drive(4'd1, 32'h0, 32'h1, 5'd8, 1'b1);
    tick();
    chk("sub_vld", 64'(valid_o), 64'd1);
    chk("sub_dat", 64'(rd_wdata_o), 64'hFFFF_FFFF);
    chk("sub_addr", 64'(wr_addr_o), 64'd8);
    idle();
    tick();
    chk("idle_vld", 64'(valid_o), 64'd0);
    chk("hold_dat", 64'(rd_wdata_o), 64'hFFFF_FFFF);

    drive(4'd10, 32'hFFFF_FFFF, 32'h2, 5'd3, 1'b1);
    tick();
    idle();
    chk("mul_busy_rdy", 64'(ready_o), 64'd0);
    chk("mul_busy_vld", 64'(valid_o), 64'd0);
    tick();
    chk("mul_vld", 64'(valid_o), 64'd1);
    chk("mul_rdy", 64'(ready_o), 64'd1);
    chk("mul_dat", 64'(rd_wdata_o), 64'hFFFF_FFFE);
    chk("mul_addr", 64'(wr_addr_o), 64'd3);
    drive(4'd11, 32'hFFFF_FFFF, 32'h2, 5'd3, 1'b1);
    tick();
    idle();
    chk("mulhu_busy_vld", 64'(valid_o), 64'd0);
    tick();
    chk("mulhu_vld", 64'(valid_o), 64'd1);
    chk("mulhu_dat", 64'(rd_wdata_o), 64'h1);

    // ADD held on valid_i while the MUL is busy: accepted once, after the MUL returns ready.
    drive(4'd10, 32'h3, 32'h5, 5'd2, 1'b1);
    tick();
    drive(4'd0, 32'd10, 32'd20, 5'd9, 1'b1);
    chk("hold_busy_rdy", 64'(ready_o), 64'd0);
    tick();
    chk("hold_mul_vld", 64'(valid_o), 64'd1);
    chk("hold_mul_dat", 64'(rd_wdata_o), 64'd15);
    chk("hold_mul_addr", 64'(wr_addr_o), 64'd2);
    tick();
    idle();
    chk("hold_add_vld", 64'(valid_o), 64'd1);
    chk("hold_add_dat", 64'(rd_wdata_o), 64'd30);
    chk("hold_add_addr", 64'(wr_addr_o), 64'd9);
    tick();
    chk("hold_once", 64'(valid_o), 64'd0);

    drive(4'd5, 32'h1, 32'h21, 5'd1, 1'b1);
    tick();
    chk("sll_dat", 64'(rd_wdata_o), 64'h2);
    drive(4'd7, 32'h8000_0000, 32'h4, 5'd1, 1'b1);
    tick();
    chk("sra_dat", 64'(rd_wdata_o), 64'hF800_0000);
    drive(4'd6, 32'h8000_0000, 32'h4, 5'd1, 1'b1);
    tick();
    chk("srl_dat", 64'(rd_wdata_o), 64'h0800_0000);
    drive(4'd8, 32'hFFFF_FFFF, 32'h1, 5'd1, 1'b1);
    tick();
    chk("slt_dat", 64'(rd_wdata_o), 64'h1);
    drive(4'd9, 32'hFFFF_FFFF, 32'h1, 5'd1, 1'b1);
    tick();
    chk("sltu_dat", 64'(rd_wdata_o), 64'h0);
    drive(4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd1, 1'b1);
    tick();
    chk("xor_dat", 64'(rd_wdata_o), 64'h0FF0_0FF0);

    drive(4'd0, 32'h1, 32'h1, 5'd0, 1'b1);
    tick();
    chk("x0_vld", 64'(valid_o), 64'd1);
    chk("x0_we", 64'(reg_we_o), 64'd0);
    drive(4'd0, 32'h1, 32'h1, 5'd6, 1'b0);
    tick();
    chk("nowe_we", 64'(reg_we_o), 64'd0);
    drive(4'd15, 32'h1, 32'h1, 5'd6, 1'b1);
    tick();
    chk("op15_vld", 64'(valid_o), 64'd1);
    chk("op15_ill", 64'(illegal_o), 64'd1);
    chk("op15_we", 64'(reg_we_o), 64'd0);
    chk("op15_dat", 64'(rd_wdata_o), 64'd0);
    idle();
    tick();
    chk("ill_pulse", 64'(illegal_o), 64'd0);

`ifdef EX_DIV_EN
    run_multi("divu", 4'd12, 32'd100, 32'd7, 32, 32'd14);
    run_multi("remu", 4'd13, 32'd100, 32'd7, 32, 32'd2);
    drive(4'd12, 32'd5, 32'd0, 5'd4, 1'b1);
    tick();
    chk("divz_vld", 64'(valid_o), 64'd1);
    chk("divz_dat", 64'(rd_wdata_o), 64'hFFFF_FFFF);
    drive(4'd13, 32'd5, 32'd0, 5'd4, 1'b1);
    tick();
    chk("remz_dat", 64'(rd_wdata_o), 64'd5);
    chk("remz_ill", 64'(illegal_o), 64'd0);
    idle();
    tick();

    drive(4'd12, 32'd100, 32'd7, 5'd4, 1'b1);
    tick();
    idle();
    for (int i = 0; i < 9; i++) tick();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    chk("rdiv_ready", 64'(ready_o), 64'd1);
    chk("rdiv_vld", 64'(valid_o), 64'd0);
    chk("rdiv_dat", 64'(rd_wdata_o), 64'd0);
    chk("rdiv_addr", 64'(wr_addr_o), 64'd0);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (valid_o) seen = 1'b1;
      end
      chk("rdiv_no_pulse", 64'(seen), 64'd0);
    end
`else
    drive(4'd12, 32'd100, 32'd7, 5'd4, 1'b1);
    tick();
    chk("op12_vld", 64'(valid_o), 64'd1);
    chk("op12_ill", 64'(illegal_o), 64'd1);
    chk("op12_we", 64'(reg_we_o), 64'd0);
    chk("op12_rdy", 64'(ready_o), 64'd1);
`endif

    drive(4'd3, 32'h1200, 32'h0034, 5'd5, 1'b1);
    tick();
    chk("or_dat", 64'(rd_wdata_o), 64'h1234);
    drive(4'd10, 32'd6, 32'd7, 5'd5, 1'b1);
    tick();
    idle();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    chk("rmul_ready", 64'(ready_o), 64'd1);
    chk("rmul_vld", 64'(valid_o), 64'd0);
    chk("rmul_dat", 64'(rd_wdata_o), 64'd0);
    chk("rmul_addr", 64'(wr_addr_o), 64'd0);
    tick();
    chk("rmul_no_pulse", 64'(valid_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_stage_mc.md
Name: ex_stage_mc

Overview:
- Parametrised multi-cycle execute stage; successor to the single-cycle ALU-only execute stage.
- Accepts one decoded instruction per handshake from decode. Executes single-cycle ALU ops, a fixed-latency multiply and an optional iterative unsigned divide.
- Presents a registered result with a one-cycle valid pulse to writeback. Writeback never back-pressures.

Parameters:
- XLEN, 32, datapath width in bits (>= 8, power of two).
- MUL_CYCLES, 2, multiply latency in cycles from acceptance to valid_o (>= 1).
- REG_ADDR_W, 5, register address width.

Ports:
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  reset, synchronous, active-low
- valid_i  input  1  decode presents an instruction
- ready_o  output  1  stage can accept (state IDLE)
- operator_i  input  4  opcode (see Behaviour)
- operand_a_i  input  XLEN  source A
- operand_b_i  input  XLEN  source B
- rd_addr_i  input  REG_ADDR_W  destination register
- rd_wr_en_i  input  1  instruction writes rd
- valid_o  output  1  one-cycle pulse, result ready
- reg_we_o  output  1  register-file write enable
- wr_addr_o  output  REG_ADDR_W  write address
- rd_wdata_o  output  XLEN  result data
- illegal_o  output  1  one-cycle pulse with valid_o for an unsupported opcode

Behaviour:
- Clocking and reset: one clock (clk_i); reset rst_ni is synchronous and active-low.
- Reset: state=IDLE; valid_o, reg_we_o, illegal_o = 0; wr_addr_o, rd_wdata_o = 0; counters = 0. Reset mid-operation aborts the op with no output pulse.
- Accept: valid_i & ready_o at a rising edge. The stage latches operator, operands, rd_addr and rd_wr_en. valid_i while ready_o=0 is ignored; decode must hold it.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA (shift amount = operand_b[$clog2(XLEN)-1:0])
  - 8 SLT (signed), 9 SLTU (zero-extended 0/1)
  - 10 MUL (low XLEN bits of product), 11 MULHU (high XLEN bits of unsigned product)
  - 12 DIVU, 13 REMU
  - 14, 15 illegal
- All arithmetic is modulo 2^XLEN; no overflow flags.
- FSM states: IDLE, MUL, DIV.
  - IDLE, accept of ops 0-9 or 14-15: stay IDLE; result registered; valid_o=1 in the next cycle. Latency 1; back-to-back issue every cycle is allowed.
  - IDLE, accept of MUL/MULHU: if MUL_CYCLES=1, behave like a single-cycle op. Otherwise go to MUL and load cnt=MUL_CYCLES-1. Decrement each cycle; at cnt reaching 0, go to IDLE with valid_o=1. valid_o is high exactly MUL_CYCLES cycles after the accept edge.
  - IDLE, accept of DIVU/REMU with divisor != 0: go to DIV; restoring divide, one quotient bit per cycle for XLEN cycles. Then go to IDLE; valid_o=1 on cycle XLEN+1 after accept.
  - DIVU/REMU with divisor = 0: fast path, latency 1. DIVU returns all-ones; REMU returns the dividend.
- ready_o = (state==IDLE). In the cycle valid_o pulses for a multi-cycle op, ready_o is already 1, so the next op may be accepted on that edge.
- Output registers:
  - reg_we_o = valid_o & latched rd_wr_en & (latched rd_addr != 0). Writes to x0 are suppressed.
  - wr_addr_o and rd_wdata_o update only when valid_o pulses and hold otherwise.
- Illegal opcode: valid_o=1, illegal_o=1, rd_wdata_o=0, reg_we_o=0, latency 1.

Optional Feature:
- Macro EX_DIV_EN.
- Defined: DIVU/REMU are implemented as above.
- Undefined: no divider logic and no DIV state. Opcodes 12/13 are treated as illegal: latency 1, illegal_o=1, reg_we_o=0, rd_wdata_o=0.

Test Plan:
- Reset, then ADD a=0x0000_0005, b=0x0000_0003, rd=7, we=1 -> next cycle valid_o=1, reg_we_o=1, wr_addr_o=7, rd_wdata_o=0x8. Then SUB 0-1 issued back-to-back -> 0xFFFF_FFFF the following cycle.
- MUL a=0xFFFF_FFFF, b=0x2 with MUL_CYCLES=2 -> ready_o=0 for 1 cycle; valid_o exactly 2 cycles after accept, rd_wdata_o=0xFFFF_FFFE. MULHU with the same operands -> 0x1.
- DIVU 100/7 (EX_DIV_EN) -> ready_o low for 32 cycles, valid_o at cycle 33, data=14. REMU 100/7 -> 2. DIVU 5/0 -> 0xFFFF_FFFF at latency 1; REMU 5/0 -> 5.
- SLL 0x1 by b=0x21 -> 0x2 (only low 5 bits used). SRA 0x8000_0000 by 4 -> 0xF800_0000. SLT -1 vs 1 -> 1; SLTU -1 vs 1 -> 0.
- Writes to x0 and illegal ops: ADD with rd=0, we=1 -> valid_o=1, reg_we_o=0. Opcode 15 -> illegal_o=1, reg_we_o=0. Without EX_DIV_EN, opcode 12 -> illegal_o=1.
- Reset mid-divide: assert rst_ni=0 at cycle 10 of a DIVU -> no valid_o pulse; ready_o=1 and all outputs 0 after the reset edge. valid_i held high while ready_o=0 during a MUL -> the op is accepted only once, on the first edge ready_o=1.
